branch_ctrl_fsm: RTL and testbench

- Multicycle control sequencer sitting directly upstream of the PC-select logic and the PC register.
- Fetches each instruction, then decodes it, then directly executes the control-flow instructions: beq, bne, ble, bgt, j, jal, jr.
- Drives PCWrite, PCWriteCond, EQorNE and GTorLT into PC-select, which combines them with the ALU Zero/Gt flags.
- Hands every other opcode to the datapath execute sequencer over a req/done handshake.

---
 rtl/branch_ctrl_fsm.sv | 139 +++++++++++++
 tb/tb_branch_ctrl_fsm.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl_fsm.sv
// Multicycle control sequencer in front of the PC-select logic and PC register.
// Runs fetch/decode and the control-flow instructions itself; other opcodes go to the execute sequencer.
module branch_ctrl_fsm #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       exec_done,
  output logic       MemRead,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       EQorNE,
  output logic       GTorLT,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ALUOutWrite,
  output logic       RegWriteRA,
  output logic       exec_req,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    sRst     = 4'd0,
    sFetch   = 4'd1,
    sMemWait = 4'd2,
    sDecode  = 4'd3,
    sBranch  = 4'd4,
    sJump    = 4'd5,
    sJalLink = 4'd6,
    sJr      = 4'd7,
    sExec    = 4'd8
  } state_t;

  state_t     state;
  state_t     nextState;
  logic [3:0] waitCnt;
  logic [5:0] opQ;

  // State register; the wait counter and the opcode copy only move in their own states
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= sRst;
      waitCnt <= 4'd0;
      opQ     <= 6'd0;
    end else begin
      state <= nextState;
      if (state == sFetch)
        waitCnt <= 4'(MEM_WAIT);
      else if (state == sMemWait)
        waitCnt <= waitCnt - 4'd1;
      if (state == sDecode)
        opQ <= opcode;
    end
  end

  // Moore outputs and next-state; everything defaults to 0 so RST drives all outputs low
  always_comb begin
    nextState   = state;
    MemRead     = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    EQorNE      = 1'b0;
    GTorLT      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    ALUOutWrite = 1'b0;
    RegWriteRA  = 1'b0;
    exec_req    = 1'b0;
    case (state)
      sRst: nextState = sFetch;
      sFetch: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        ALUOp     = 3'b001;
        PCWrite   = 1'b1;
        nextState = sMemWait;
      end
      sMemWait: begin
        MemRead = 1'b1;
        if (waitCnt == 4'd1) begin
          IRWrite   = 1'b1;
          nextState = sDecode;
        end
      end
      sDecode: begin
        ALUSrcB     = 2'b11;
        ALUOp       = 3'b001;
        ALUOutWrite = 1'b1;
        case (opcode)
          6'h04, 6'h05, 6'h06, 6'h07: nextState = sBranch;
          6'h02:                      nextState = sJump;
          6'h03:                      nextState = sJalLink;
          6'h00:                      nextState = (funct == 6'h08) ? sJr : sExec;
          default:                    nextState = sExec;
        endcase
      end
      sBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b010;
        PCSource    = 2'b01;
        PCWriteCond = 1'b1;
        EQorNE      = (opQ == 6'h04) || (opQ == 6'h06);
        GTorLT      = (opQ == 6'h07);
        nextState   = sFetch;
      end
      sJump: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        nextState = sFetch;
      end
      sJalLink: begin
        RegWriteRA = 1'b1;
        nextState  = sJump;
      end
      sJr: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b11;
        nextState = sFetch;
      end
      sExec: begin
        exec_req = 1'b1;
        if (exec_done)
          nextState = sFetch;
      end
      default: nextState = sRst;
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_branch_ctrl_fsm.sv
// Self-checking bench for branch_ctrl_fsm: per-instruction cycle schedules built from the
// instruction-level timing rules are compared cycle by cycle against two builds (MEM_WAIT=1 and 3).
module tb_branch_ctrl_fsm;

  typedef struct packed {
    logic       memRead;
    logic       irWrite;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       eqOrNe;
    logic       gtOrLt;
    logic [1:0] pcSource;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       aluOutWrite;
    logic       regWriteRa;
    logic       execReq;
    logic [3:0] state;
  } outVec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       exec_done = 1'b0;

  logic       memRead1, irWrite1, pcWrite1, pcWriteCond1, eqOrNe1, gtOrLt1;
  logic [1:0] pcSource1, aluSrcB1;
  logic       aluSrcA1, aluOutWrite1, regWriteRa1, execReq1;
  logic [2:0] aluOp1;
  logic [3:0] state1;

  logic       memRead3, irWrite3, pcWrite3, pcWriteCond3, eqOrNe3, gtOrLt3;
  logic [1:0] pcSource3, aluSrcB3;
  logic       aluSrcA3, aluOutWrite3, regWriteRa3, execReq3;
  logic [2:0] aluOp3;
  logic [3:0] state3;

  outVec_t obs1, obs3;
  outVec_t expQ[$];
  logic    doneQ[$];
  int      testsRun = 0;
  int      testsFailed = 0;

  always #5 clk = ~clk;

  branch_ctrl_fsm #(.MEM_WAIT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .exec_done(exec_done),
    .MemRead(memRead1), .IRWrite(irWrite1), .PCWrite(pcWrite1), .PCWriteCond(pcWriteCond1),
    .EQorNE(eqOrNe1), .GTorLT(gtOrLt1), .PCSource(pcSource1), .ALUSrcA(aluSrcA1),
    .ALUSrcB(aluSrcB1), .ALUOp(aluOp1), .ALUOutWrite(aluOutWrite1), .RegWriteRA(regWriteRa1),
    .exec_req(execReq1), .state_out(state1)
  );

  branch_ctrl_fsm #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .exec_done(exec_done),
    .MemRead(memRead3), .IRWrite(irWrite3), .PCWrite(pcWrite3), .PCWriteCond(pcWriteCond3),
    .EQorNE(eqOrNe3), .GTorLT(gtOrLt3), .PCSource(pcSource3), .ALUSrcA(aluSrcA3),
    .ALUSrcB(aluSrcB3), .ALUOp(aluOp3), .ALUOutWrite(aluOutWrite3), .RegWriteRA(regWriteRa3),
    .exec_req(execReq3), .state_out(state3)
  );

  assign obs1 = {memRead1, irWrite1, pcWrite1, pcWriteCond1, eqOrNe1, gtOrLt1, pcSource1,
                 aluSrcA1, aluSrcB1, aluOp1, aluOutWrite1, regWriteRa1, execReq1, state1};
  assign obs3 = {memRead3, irWrite3, pcWrite3, pcWriteCond3, eqOrNe3, gtOrLt3, pcSource3,
                 aluSrcA3, aluSrcB3, aluOp3, aluOutWrite3, regWriteRa3, execReq3, state3};

  // Expected per-cycle outputs of one whole instruction, plus the exec_done value to drive in each cycle
  function automatic void buildInstr(input logic [5:0] op, input logic [5:0] fn,
                                     input int dwell, input int mw);
    outVec_t v;
    v = '0; v.state = 4'd1; v.memRead = 1'b1; v.aluSrcB = 2'b01; v.aluOp = 3'b001; v.pcWrite = 1'b1;
    expQ.push_back(v); doneQ.push_back(1'($urandom_range(0, 1)));
    for (int k = mw; k >= 1; k--) begin
      v = '0; v.state = 4'd2; v.memRead = 1'b1; v.irWrite = (k == 1);
      expQ.push_back(v); doneQ.push_back(1'($urandom_range(0, 1)));
    end
    v = '0; v.state = 4'd3; v.aluSrcB = 2'b11; v.aluOp = 3'b001; v.aluOutWrite = 1'b1;
    expQ.push_back(v); doneQ.push_back(1'($urandom_range(0, 1)));
    if (op >= 6'h04 && op <= 6'h07) begin
      v = '0; v.state = 4'd4; v.aluSrcA = 1'b1; v.aluOp = 3'b010; v.pcSource = 2'b01;
      v.pcWriteCond = 1'b1; v.eqOrNe = (op == 6'h04 || op == 6'h06); v.gtOrLt = (op == 6'h07);
      expQ.push_back(v); doneQ.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'h02 || op == 6'h03) begin
      if (op == 6'h03) begin
        v = '0; v.state = 4'd6; v.regWriteRa = 1'b1;
        expQ.push_back(v); doneQ.push_back(1'($urandom_range(0, 1)));
      end
      v = '0; v.state = 4'd5; v.pcWrite = 1'b1; v.pcSource = 2'b10;
      expQ.push_back(v); doneQ.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'h00 && fn == 6'h08) begin
      v = '0; v.state = 4'd7; v.pcWrite = 1'b1; v.pcSource = 2'b11;
      expQ.push_back(v); doneQ.push_back(1'($urandom_range(0, 1)));
    end else begin
      for (int c = 1; c <= dwell; c++) begin
        v = '0; v.state = 4'd8; v.execReq = 1'b1;
        expQ.push_back(v); doneQ.push_back(c == dwell);
      end
    end
  endfunction

  task automatic doReset();
    exec_done = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exec_done = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      testsRun++;
      if (obs1 !== outVec_t'(0) || obs3 !== outVec_t'(0)) begin
        testsFailed++;
        $display("[TB] FAIL resetHeld cycle %0d: got %h / %h, expected 0", i, obs1, obs3);
      end
    end
    reset_n = 1'b1;
    #1;
    testsRun++;
    if (obs1 !== outVec_t'(0)) begin
      testsFailed++;
      $display("[TB] FAIL resetRelease: got %h, expected 0 (state RST)", obs1);
    end
    @(negedge clk);
  endtask

  task automatic test_beq();
    outVec_t e;
    int cyc = 0;
    opcode = 6'h04; funct = 6'($urandom);
    buildInstr(opcode, funct, 1, 1);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); exec_done = doneQ.pop_front();
      testsRun++;
      if (obs1 !== e) begin
        testsFailed++;
        $display("[TB] FAIL beq cycle %0d: got %h, expected %h", cyc, obs1, e);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_jal();
    outVec_t e;
    int cyc = 0;
    opcode = 6'h03; funct = 6'($urandom);
    buildInstr(opcode, funct, 1, 1);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); exec_done = doneQ.pop_front();
      testsRun++;
      if (obs1 !== e) begin
        testsFailed++;
        $display("[TB] FAIL jal cycle %0d: got %h, expected %h", cyc, obs1, e);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_jr_vs_add();
    outVec_t e;
    int cyc = 0;
    opcode = 6'h00; funct = 6'h08;
    buildInstr(opcode, funct, 1, 1);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); exec_done = doneQ.pop_front();
      testsRun++;
      if (obs1 !== e) begin
        testsFailed++;
        $display("[TB] FAIL jr cycle %0d: got %h, expected %h", cyc, obs1, e);
      end
      cyc++;
      @(negedge clk);
    end
    cyc = 0;
    funct = 6'h20;
    buildInstr(opcode, funct, 3, 1);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); exec_done = doneQ.pop_front();
      testsRun++;
      if (obs1 !== e) begin
        testsFailed++;
        $display("[TB] FAIL add cycle %0d: got %h, expected %h", cyc, obs1, e);
      end
      cyc++;
      @(negedge clk);
    end
    exec_done = 1'b0;
    testsRun++;
    if (execReq1 !== 1'b0 || state1 !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL addRelease: exec_req %b state %0d, expected 0 and 1", execReq1, state1);
    end
  endtask

  task automatic test_back_to_back();
    outVec_t e;
    int kind, cyc;
    for (int n = 0; n < 25; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin opcode = 6'(4 + $urandom_range(0, 3)); funct = 6'($urandom); end
        1: begin opcode = 6'h02; funct = 6'($urandom); end
        2: begin opcode = 6'h03; funct = 6'($urandom); end
        3: begin opcode = 6'h00; funct = 6'h08; end
        4: begin opcode = 6'h00; funct = 6'($urandom); end
        default: begin opcode = 6'($urandom); funct = 6'($urandom); end
      endcase
      buildInstr(opcode, funct, $urandom_range(1, 4), 1);
      cyc = 0;
      while (expQ.size() > 0) begin
        e = expQ.pop_front(); exec_done = doneQ.pop_front();
        testsRun++;
        if (obs1 !== e) begin
          testsFailed++;
          $display("[TB] FAIL backToBack instr %0d op %h fn %h cycle %0d: got %h, expected %h",
                   n, opcode, funct, cyc, obs1, e);
        end
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_mem_wait3();
    outVec_t e;
    int cyc = 0;
    doReset();
    opcode = 6'(4 + $urandom_range(0, 3)); funct = 6'($urandom);
    buildInstr(opcode, funct, 1, 3);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); exec_done = doneQ.pop_front();
      testsRun++;
      if (obs3 !== e) begin
        testsFailed++;
        $display("[TB] FAIL memWait3 cycle %0d: got %h, expected %h", cyc, obs3, e);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_mid_exec_reset();
    outVec_t e;
    doReset();
    opcode = 6'h23; funct = 6'($urandom);
    buildInstr(opcode, funct, 10, 1);
    for (int cyc = 0; cyc < 5; cyc++) begin
      e = expQ.pop_front(); exec_done = doneQ.pop_front();
      testsRun++;
      if (obs1 !== e) begin
        testsFailed++;
        $display("[TB] FAIL midExecRun cycle %0d: got %h, expected %h", cyc, obs1, e);
      end
      if (cyc < 4) @(negedge clk);
    end
    expQ.delete(); doneQ.delete();
    #2 reset_n = 1'b0;
    #1;
    testsRun++;
    if (obs1 !== outVec_t'(0)) begin
      testsFailed++;
      $display("[TB] FAIL midExecAsync: got %h, expected 0", obs1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    testsRun++;
    if (state1 !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL midExecRestart: state %0d, expected 0", state1);
    end
    @(negedge clk);
    testsRun++;
    if (state1 !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL midExecFetch: state %0d, expected 1", state1);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_jal();
    test_jr_vs_add();
    test_back_to_back();
    test_mem_wait3();
    test_mid_exec_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
